mem_stage_lsu: RTL and testbench

- MEM-stage load/store unit. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Issues data-memory requests over a valid/ready request channel and a valid-only response channel.
- Aligns store data into byte lanes, formats load data (extract, sign/zero extend) and stalls the upstream pipeline while a memory access is pending.
- Its outputs drive the MEM/WB register directly: alu_out_mem, r_data_mem, rd_mem, reg_write_mem, mem_to_reg_mem.

---
 rtl/mem_pkg.sv | 42 ++++
 rtl/lsu_load_align.sv | 29 ++
 rtl/mem_stage_lsu.sv | 123 ++++++++++++
 tb/tb_mem_stage_lsu.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store unit.
// Access sizes, FSM state codes, store byte-enable/lane functions, load extenders.
package mem_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_WAIT_RSP = 2'b01;
    localparam logic [1:0] ST_DONE     = 2'b10;

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_B:   return 4'b0001 << off;
            MEM_H:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the narrow datum across every lane so the memory picks it by byte enable.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        case (size)
            MEM_B:   return {4{data[7:0]}};
            MEM_H:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == MEM_H) && off[0]) || (size[1] && (off != 2'b00));
    endfunction

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic uns);
        return uns ? {24'b0, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic uns);
        return uns ? {16'b0, h} : {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Little-endian load formatter: picks the addressed byte/half from the
// returned word and sign- or zero-extends it.
module lsu_load_align
    import mem_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic [D_WIDTH-1:0] word,
    input  logic [1:0]         off,
    input  logic [1:0]         size,
    input  logic               uns,
    output logic [D_WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{off, 3'b000} +: 8];
    assign half_sel = word[{off[1], 4'b0000} +: 16];

    always_comb begin
        case (size)
            MEM_B:   data = ext8(byte_sel, uns);
            MEM_H:   data = ext16(half_sel, uns);
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-memory requests, formats load data
// and stalls the upstream pipeline while an access is outstanding.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int RF_SIZE = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [D_WIDTH-1:0] alu_out_ex,
    input  logic [D_WIDTH-1:0] store_data_ex,
    input  logic [RF_SIZE-1:0] rd_ex,
    input  logic               reg_write_ex,
    input  logic               mem_read_ex,
    input  logic               mem_write_ex,
    input  logic [1:0]         mem_size_ex,
    input  logic               mem_unsigned_ex,
    output logic               dmem_req_valid,
    input  logic               dmem_req_ready,
    output logic [D_WIDTH-1:0] dmem_addr,
    output logic               dmem_we,
    output logic [3:0]         dmem_be,
    output logic [D_WIDTH-1:0] dmem_wdata,
    input  logic               dmem_rsp_valid,
    input  logic [D_WIDTH-1:0] dmem_rsp_data,
    output logic               stall,
    output logic               misalign_exc,
    output logic [D_WIDTH-1:0] alu_out_mem,
    output logic [D_WIDTH-1:0] r_data_mem,
    output logic [RF_SIZE-1:0] rd_mem,
    output logic               reg_write_mem,
    output logic               mem_to_reg_mem
);

    logic [1:0]         state, state_nx;
    logic [1:0]         off_q, size_q;
    logic               uns_q;
    logic [D_WIDTH-1:0] data_q, load_fmt;
    logic               is_mem, is_store, load_accept;

    assign is_mem   = ex_valid & (mem_read_ex | mem_write_ex);
    assign is_store = mem_write_ex;

    lsu_load_align #(.D_WIDTH(D_WIDTH)) u_align (
        .word (dmem_rsp_data),
        .off  (off_q),
        .size (size_q),
        .uns  (uns_q),
        .data (load_fmt)
    );

    always_comb begin
        state_nx       = state;
        load_accept    = 1'b0;
        dmem_req_valid = 1'b0;
        dmem_addr      = '0;
        dmem_we        = 1'b0;
        dmem_be        = 4'b0000;
        dmem_wdata     = '0;
        stall          = 1'b0;
        misalign_exc   = 1'b0;
        alu_out_mem    = ex_valid ? alu_out_ex : '0;
        rd_mem         = ex_valid ? rd_ex : '0;
        r_data_mem     = '0;
        reg_write_mem  = 1'b0;
        mem_to_reg_mem = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!is_mem) begin
                    reg_write_mem = ex_valid & reg_write_ex;
                end else if (misaligned(mem_size_ex, alu_out_ex[1:0])) begin
                    misalign_exc = 1'b1;
                end else begin
                    // Fields are driven straight from EX/MEM, which the stall keeps frozen.
                    dmem_req_valid = 1'b1;
                    dmem_addr      = {alu_out_ex[D_WIDTH-1:2], 2'b00};
                    dmem_we        = is_store;
                    if (is_store) begin
                        dmem_be    = store_be(mem_size_ex, alu_out_ex[1:0]);
                        dmem_wdata = store_lanes(mem_size_ex, store_data_ex);
                    end else begin
                        dmem_be    = 4'b1111;
                    end
                    stall       = ~(is_store & dmem_req_ready);
                    load_accept = ~is_store & dmem_req_ready;
                    if (load_accept) state_nx = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                stall = 1'b1;
                if (dmem_rsp_valid) state_nx = ST_DONE;
            end
            ST_DONE: begin
                reg_write_mem  = reg_write_ex;
                mem_to_reg_mem = 1'b1;
                r_data_mem     = data_q;
                state_nx       = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            off_q  <= '0;
            size_q <= '0;
            uns_q  <= 1'b0;
            data_q <= '0;
        end else begin
            state <= state_nx;
            if (load_accept) begin
                off_q  <= alu_out_ex[1:0];
                size_q <= mem_size_ex;
                uns_q  <= mem_unsigned_ex;
            end
            if (state == ST_WAIT_RSP && dmem_rsp_valid) data_q <= load_fmt;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a table of single-cycle IDLE vectors plus
// hand-written load, back-pressured store and mid-access reset sequences.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] alu_out_ex, store_data_ex;
    logic [4:0]  rd_ex;
    logic        reg_write_ex, mem_read_ex, mem_write_ex;
    logic [1:0]  mem_size_ex;
    logic        mem_unsigned_ex;
    logic        dmem_req_valid, dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_data;
    logic        stall, misalign_exc;
    logic [31:0] alu_out_mem, r_data_mem;
    logic [4:0]  rd_mem;
    logic        reg_write_mem, mem_to_reg_mem;

    int ntests = 0;
    int nfail  = 0;

    mem_stage_lsu #(.D_WIDTH(32), .RF_SIZE(5)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid),
        .alu_out_ex(alu_out_ex), .store_data_ex(store_data_ex), .rd_ex(rd_ex),
        .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
        .mem_size_ex(mem_size_ex), .mem_unsigned_ex(mem_unsigned_ex),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
        .stall(stall), .misalign_exc(misalign_exc),
        .alu_out_mem(alu_out_mem), .r_data_mem(r_data_mem), .rd_mem(rd_mem),
        .reg_write_mem(reg_write_mem), .mem_to_reg_mem(mem_to_reg_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw, mr, mw;
        logic [1:0]  size;
        logic        uns, ready;
        logic        e_req, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wdata;
        logic        e_stall, e_mis, e_rw;
        logic [31:0] e_alu;
        logic [4:0]  e_rd;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; alu_out_ex = 32'h0; store_data_ex = 32'h0; rd_ex = 5'd0;
        reg_write_ex = 1'b0; mem_read_ex = 1'b0; mem_write_ex = 1'b0;
        mem_size_ex = 2'b00; mem_unsigned_ex = 1'b0; dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0; dmem_rsp_data = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string nm, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] rsp, input int unsigned delay,
                           input logic [31:0] exp);
        ex_valid = 1'b1; alu_out_ex = addr; rd_ex = 5'd5; reg_write_ex = 1'b1;
        mem_read_ex = 1'b1; mem_write_ex = 1'b0; mem_size_ex = size; mem_unsigned_ex = uns;
        dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
        #1;
        chk1({nm, "_acc_stall"}, stall, 1'b1);
        chk1({nm, "_acc_req"}, dmem_req_valid, 1'b1);
        chk1({nm, "_acc_we"}, dmem_we, 1'b0);
        chk({nm, "_acc_be"}, {28'b0, dmem_be}, 32'hF);
        chk({nm, "_acc_addr"}, dmem_addr, {addr[31:2], 2'b00});
        step();
        dmem_req_ready = 1'b0;
        for (int unsigned i = 0; i < delay; i++) begin
            #1;
            chk1({nm, "_wait_stall"}, stall, 1'b1);
            step();
        end
        dmem_rsp_valid = 1'b1; dmem_rsp_data = rsp;
        #1;
        chk1({nm, "_rsp_stall"}, stall, 1'b1);
        chk1({nm, "_rsp_req"}, dmem_req_valid, 1'b0);
        chk1({nm, "_rsp_rw"}, reg_write_mem, 1'b0);
        step();
        dmem_rsp_valid = 1'b0; dmem_rsp_data = 32'hFFFF_FFFF;
        #1;
        chk1({nm, "_done_stall"}, stall, 1'b0);
        chk1({nm, "_done_m2r"}, mem_to_reg_mem, 1'b1);
        chk1({nm, "_done_rw"}, reg_write_mem, 1'b1);
        chk({nm, "_done_rdata"}, r_data_mem, exp);
        chk({nm, "_done_rd"}, {27'b0, rd_mem}, 32'd5);
        step();
        idle_inputs();
        #1;
        chk1({nm, "_after_stall"}, stall, 1'b0);
        chk1({nm, "_after_m2r"}, mem_to_reg_mem, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1,
                     1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0};
        vecs[1]  = '{1'b1, 32'h12345678, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1,
                     1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h12345678, 5'd7};
        vecs[2]  = '{1'b1, 32'h102, 32'h1234ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1,
                     1'b1, 1'b1, 4'hC, 32'h100, 32'hABCDABCD, 1'b0, 1'b0, 1'b0, 32'h102, 5'd0};
        vecs[3]  = '{1'b1, 32'h101, 32'h000000EE, 5'd4, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1,
                     1'b1, 1'b1, 4'h2, 32'h100, 32'hEEEEEEEE, 1'b0, 1'b0, 1'b0, 32'h101, 5'd4};
        vecs[4]  = '{1'b1, 32'h204, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1,
                     1'b1, 1'b1, 4'hF, 32'h204, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'h204, 5'd0};
        vecs[5]  = '{1'b1, 32'h101, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1,
                     1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h101, 5'd9};
        vecs[6]  = '{1'b1, 32'h103, 32'h5555, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1,
                     1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h103, 5'd0};
        vecs[7]  = '{1'b1, 32'h100, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0,
                     1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 32'h100, 5'd2};
        vecs[8]  = '{1'b1, 32'h3, 32'h7A, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0,
                     1'b1, 1'b1, 4'h8, 32'h0, 32'h7A7A7A7A, 1'b1, 1'b0, 1'b0, 32'h3, 5'd0};
        vecs[9]  = '{1'b1, 32'h10, 32'h01020304, 5'd1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1,
                     1'b1, 1'b1, 4'hF, 32'h10, 32'h01020304, 1'b0, 1'b0, 1'b0, 32'h10, 5'd1};
        vecs[10] = '{1'b0, 32'h101, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1,
                     1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0};
        vecs[11] = '{1'b1, 32'h202, 32'h1, 5'd0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1,
                     1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h202, 5'd0};

        rst = 1'b1;
        idle_inputs();
        #1;
        chk1("reset_stall", stall, 1'b0);
        chk1("reset_req", dmem_req_valid, 1'b0);
        chk1("reset_rw", reg_write_mem, 1'b0);
        chk("reset_alu", alu_out_mem, 32'h0);
        chk("reset_rdata", r_data_mem, 32'h0);
        step();
        step();
        #2 rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            ex_valid = vecs[i].ev; alu_out_ex = vecs[i].alu; store_data_ex = vecs[i].sd;
            rd_ex = vecs[i].rd; reg_write_ex = vecs[i].rw; mem_read_ex = vecs[i].mr;
            mem_write_ex = vecs[i].mw; mem_size_ex = vecs[i].size;
            mem_unsigned_ex = vecs[i].uns; dmem_req_ready = vecs[i].ready;
            #1;
            chk1($sformatf("v%0d_req", i), dmem_req_valid, vecs[i].e_req);
            chk1($sformatf("v%0d_we", i), dmem_we, vecs[i].e_we);
            chk($sformatf("v%0d_be", i), {28'b0, dmem_be}, {28'b0, vecs[i].e_be});
            chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].e_addr);
            if (vecs[i].e_we)
                chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
            chk1($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
            chk1($sformatf("v%0d_mis", i), misalign_exc, vecs[i].e_mis);
            chk1($sformatf("v%0d_rw", i), reg_write_mem, vecs[i].e_rw);
            chk1($sformatf("v%0d_m2r", i), mem_to_reg_mem, 1'b0);
            chk($sformatf("v%0d_alu", i), alu_out_mem, vecs[i].e_alu);
            chk($sformatf("v%0d_rd", i), {27'b0, rd_mem}, {27'b0, vecs[i].e_rd});
            step();
        end
        idle_inputs();
        step();

        do_load("lw",  32'h100, 2'b10, 1'b0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        do_load("lb",  32'h103, 2'b00, 1'b0, 32'h80AABBCC, 0, 32'hFFFFFF80);
        do_load("lbu", 32'h103, 2'b00, 1'b1, 32'h80AABBCC, 0, 32'h00000080);
        do_load("lhu", 32'h102, 2'b01, 1'b1, 32'h80AABBCC, 0, 32'h000080AA);
        do_load("lh0", 32'h200, 2'b01, 1'b0, 32'h1234F00D, 2, 32'hFFFFF00D);
        do_load("lb1", 32'h201, 2'b00, 1'b0, 32'h00007F00, 1, 32'h0000007F);

        // Store held off by the memory for three cycles.
        ex_valid = 1'b1; alu_out_ex = 32'h300; store_data_ex = 32'h11223344;
        mem_write_ex = 1'b1; mem_size_ex = 2'b10; dmem_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk1($sformatf("swbp%0d_stall", c), stall, 1'b1);
            chk1($sformatf("swbp%0d_req", c), dmem_req_valid, 1'b1);
            chk($sformatf("swbp%0d_addr", c), dmem_addr, 32'h300);
            chk($sformatf("swbp%0d_wdata", c), dmem_wdata, 32'h11223344);
            chk($sformatf("swbp%0d_be", c), {28'b0, dmem_be}, 32'hF);
            step();
        end
        dmem_req_ready = 1'b1;
        #1;
        chk1("swbp_acc_stall", stall, 1'b0);
        chk1("swbp_acc_req", dmem_req_valid, 1'b1);
        chk1("swbp_acc_we", dmem_we, 1'b1);
        step();
        idle_inputs();
        #1;
        chk1("swbp_after_req", dmem_req_valid, 1'b0);
        step();

        // Reset while waiting for a load response.
        ex_valid = 1'b1; alu_out_ex = 32'h400; rd_ex = 5'd6; reg_write_ex = 1'b1;
        mem_read_ex = 1'b1; mem_size_ex = 2'b10; dmem_req_ready = 1'b1;
        step();
        #1;
        chk1("rstmid_wait_stall", stall, 1'b1);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk1("rstmid_stall", stall, 1'b0);
        chk1("rstmid_req", dmem_req_valid, 1'b0);
        chk1("rstmid_rw", reg_write_mem, 1'b0);
        chk1("rstmid_m2r", mem_to_reg_mem, 1'b0);
        chk("rstmid_rdata", r_data_mem, 32'h0);
        step();
        #2 rst = 1'b0;
        do_load("lw_post_rst", 32'h104, 2'b10, 1'b0, 32'h0BADF00D, 0, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
